// File: rtl/intt_gs_butterfly.sv
// Three-stage Gentleman-Sande butterfly for the inverse NTT over p = 2^16+1.
// Optional per-stage halving of both results is enabled with INTT_HALVE_EN.
module intt_gs_butterfly #(
    parameter int WIDTH = 17,
    parameter int PRIME = 65537,
    parameter int M     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_w,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic             out_last
);

    localparam int SW = WIDTH + 1;
    localparam int PW = 2 * WIDTH;
    localparam int HW = PW - M;
    localparam int TW = HW + 1;
    localparam logic [SW-1:0] P_S = SW'(PRIME);
    localparam logic [TW-1:0] P_T = TW'(PRIME);

    logic             v1, v2, v3;
    logic             en;
    logic [WIDTH-1:0] x1, d1, w1;
    logic             last1;
    logic [WIDTH-1:0] x2;
    logic [PW-1:0]    prod2;
    logic             last2;

    logic [SW-1:0]    sum_s, diff_s, x1_next, y1_next;
    logic [PW-1:0]    prod_next;
    logic [TW-1:0]    lo_ext, hi_ext, t_s, y_red;
    logic [WIDTH-1:0] x_fin, y_fin;

`ifdef INTT_HALVE_EN
    // Multiply by 2^-1 mod p: odd values become even by adding p first.
    function automatic logic [WIDTH-1:0] halve(input logic [WIDTH-1:0] v);
        logic [SW-1:0] e;
        e = v[0] ? ({1'b0, v} + P_S) : {1'b0, v};
        return e[SW-1:1];
    endfunction
`endif

    assign en        = out_ready | ~v3;
    assign in_ready  = en;
    assign out_valid = v3;

    // Modular add and subtract on the incoming pair
    always_comb begin
        sum_s   = {1'b0, in_a} + {1'b0, in_b};
        x1_next = (sum_s >= P_S) ? (sum_s - P_S) : sum_s;
        diff_s  = {1'b0, in_a} - {1'b0, in_b};
        y1_next = diff_s[SW-1] ? (diff_s + P_S) : diff_s;
    end

    assign prod_next = {{WIDTH{1'b0}}, d1} * {{WIDTH{1'b0}}, w1};

    // Fermat reduction: 2^M == -1 mod p, so the product folds to lo - hi
    always_comb begin
        lo_ext = {{(TW-M){1'b0}}, prod2[M-1:0]};
        hi_ext = {1'b0, prod2[PW-1:M]};
        t_s    = lo_ext - hi_ext;
        y_red  = t_s[TW-1] ? (t_s + P_T) : t_s;
`ifdef INTT_HALVE_EN
        x_fin  = halve(x2);
        y_fin  = halve(y_red[WIDTH-1:0]);
`else
        x_fin  = x2;
        y_fin  = y_red[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            x1       <= '0;
            d1       <= '0;
            w1       <= '0;
            last1    <= 1'b0;
            x2       <= '0;
            prod2    <= '0;
            last2    <= 1'b0;
            out_x    <= '0;
            out_y    <= '0;
            out_last <= 1'b0;
        end else if (en) begin
            v1       <= in_valid;
            x1       <= x1_next[WIDTH-1:0];
            d1       <= y1_next[WIDTH-1:0];
            w1       <= in_w;
            last1    <= in_last;
            v2       <= v1;
            x2       <= x1;
            prod2    <= prod_next;
            last2    <= last1;
            v3       <= v2;
            out_x    <= x_fin;
            out_y    <= y_fin;
            out_last <= last2;
        end
    end

endmodule

// File: tb/tb_intt_gs_butterfly.sv
// Self-checking bench for intt_gs_butterfly: directed beats, stall, reset and random traffic
// checked against a modular-arithmetic scoreboard (honours INTT_HALVE_EN).
module tb_intt_gs_butterfly;

    localparam longint P = 65537;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [16:0] in_a = '0, in_b = '0, in_w = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [16:0] out_x, out_y;
    logic        out_last;

    typedef struct {
        longint x;
        longint y;
        bit     last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_popped = 0;
    bit   rand_done = 0;

    intt_gs_butterfly #(.WIDTH(17), .PRIME(65537), .M(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: plain modular arithmetic; halving is multiplication by 2^-1 = 32769
    function automatic exp_t model(input longint a, input longint b, input longint w, input bit last);
        exp_t e;
        e.x = (a + b) % P;
        e.y = (((a - b + P) % P) * w) % P;
`ifdef INTT_HALVE_EN
        e.x = (e.x * 32769) % P;
        e.y = (e.y * 32769) % P;
`endif
        e.last = last;
        return e;
    endfunction

    // Scoreboard: push on accepted input, compare head whenever output is valid
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected out_valid", 1, 0);
                end else begin
                    checkOutput("sb out_x", out_x, exp_q[0].x);
                    checkOutput("sb out_y", out_y, exp_q[0].y);
                    checkOutput("sb out_last", out_last, exp_q[0].last);
                    checkOutput("sb out_x range", out_x < P, 1);
                    checkOutput("sb out_y range", out_y < P, 1);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_popped++;
                    end
                end
            end
            checkOutput("sb in_ready", in_ready, out_ready || !out_valid);
            if (in_valid && in_ready)
                exp_q.push_back(model(in_a, in_b, in_w, in_last));
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one beat, holding it until the block accepts it
    task automatic applyStimulus(input longint a, input longint b, input longint w, input bit last);
        bit acc;
        in_a = 17'(a); in_b = 17'(b); in_w = 17'(w); in_last = last;
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        checkOutput("accept timeout", 0, 1);
    endtask

    task automatic directedBeat(input longint a, input longint b, input longint w,
                                input longint ex, input longint ey);
        applyStimulus(a, b, w, 1'b0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("latency early", out_valid, 0);
        @(posedge clk); #1;
        checkOutput("latency valid", out_valid, 1);
        checkOutput("lit out_x", out_x, ex);
        checkOutput("lit out_y", out_y, ey);
        @(posedge clk); #1;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        checkOutput("drain remaining", exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        #2;
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_x", out_x, 0);
        checkOutput("reset out_y", out_y, 0);
        checkOutput("reset out_last", out_last, 0);
        checkOutput("reset in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Hand-computed vectors
`ifdef INTT_HALVE_EN
        directedBeat(5, 3, 2, 4, 2);
        directedBeat(3, 5, 1, 4, 65536);
        directedBeat(65536, 65536, 65536, 65536, 0);
        directedBeat(65536, 0, 65536, 32768, 32769);
        directedBeat(3, 0, 1, 32770, 32770);
`else
        directedBeat(5, 3, 2, 8, 4);
        directedBeat(3, 5, 1, 8, 65535);
        directedBeat(65536, 65536, 65536, 65535, 0);
        directedBeat(65536, 0, 65536, 65536, 1);
        directedBeat(3, 0, 1, 3, 3);
`endif

        // Eight back-to-back beats with a five-cycle output stall
        n_popped = 0;
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    applyStimulus(1000 * i + 7, (i * 4321) % 65537, i + 3, i == 8);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                checkOutput("stall in_ready", in_ready, 0);
                checkOutput("stall out_valid", out_valid, 1);
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        waitDrain();
        checkOutput("stall beat count", n_popped, 8);

        // Reset with three beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(100 + i, 50, 7, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset out_valid", out_valid, 0);
        checkOutput("midreset out_x", out_x, 0);
        checkOutput("midreset out_y", out_y, 0);
        checkOutput("midreset in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            checkOutput("no stale beat", out_valid, 0);
        end
`ifdef INTT_HALVE_EN
        directedBeat(5, 3, 2, 4, 2);
`else
        directedBeat(5, 3, 2, 8, 4);
`endif

        // Random traffic with random back-pressure
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    applyStimulus($urandom_range(0, 65536), $urandom_range(0, 65536),
                                  $urandom_range(0, 65536), $urandom_range(0, 15) == 0);
                end
                in_valid = 1'b0;
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
